// File: rtl/gigatron_ram_arbiter_pkg.sv
// Shared definitions for the Gigatron RAM arbiter: port indices, RAM widths
// and the registered data-phase record.
package gigatron_ram_arbiter_pkg;

    localparam int   RAM_AW = 16;
    localparam int   RAM_DW = 8;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              owner;
        logic              we;
        logic [RAM_DW-1:0] wdata;
    } dphase_t;

    // Width of a counter that must reach limit; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/gigatron_arb_pick.sv
// Grant selection between the preferred CPU port A and port B, with a
// saturating counter that forces a B grant after STARVE_LIMIT A wins.
module gigatron_arb_pick
    import gigatron_ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = cnt_width(STARVE_LIMIT)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_a_req,
    input  logic             i_b_req,
    output logic             o_grant_a,
    output logic             o_grant_b,
    output logic [CNT_W-1:0] o_starve_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_starved;

    assign w_starved = (r_cnt == CNT_W'(STARVE_LIMIT));

    // B only wins a contested cycle once A has used up its allowance.
    assign o_grant_b = !i_reset && i_b_req && (!i_a_req || w_starved);
    assign o_grant_a = !i_reset && i_a_req && !o_grant_b;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (!i_b_req || o_grant_b) begin
            r_cnt <= '0;
        end else if (o_grant_a && !w_starved) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starve_cnt = r_cnt;

endmodule

// File: rtl/gigatron_ram_arbiter.sv
// Two-port arbiter in front of a registered-address RAM: address phase in the
// ack cycle, data phase one cycle later, one transaction per cycle.
module gigatron_ram_arbiter
    import gigatron_ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_a_req,
    input  logic                               i_a_we,
    input  logic [RAM_AW-1:0]                  i_a_addr,
    input  logic [RAM_DW-1:0]                  i_a_wdata,
    output logic                               o_a_ack,
    output logic                               o_a_rvalid,
    output logic [RAM_DW-1:0]                  o_a_rdata,
    input  logic                               i_b_req,
    input  logic                               i_b_we,
    input  logic [RAM_AW-1:0]                  i_b_addr,
    input  logic [RAM_DW-1:0]                  i_b_wdata,
    output logic                               o_b_ack,
    output logic                               o_b_rvalid,
    output logic [RAM_DW-1:0]                  o_b_rdata,
    output logic [RAM_AW-1:0]                  o_ram_addr,
    output logic                               o_ram_we,
    output logic [RAM_DW-1:0]                  o_ram_wdata,
    input  logic [RAM_DW-1:0]                  i_ram_rdata,
    output logic [cnt_width(STARVE_LIMIT)-1:0] o_dbg_starve_cnt
);

    // Handshake: a requester holds req/we/addr/wdata until ack is high at a
    // rising edge; that edge accepts the request. rvalid marks rdata valid
    // in the cycle after a read's ack and has no back-pressure.

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_any_grant;
    logic [RAM_AW-1:0] w_ram_addr;
    logic              w_sel_we;
    logic [RAM_DW-1:0] w_sel_wdata;
    logic              w_dp_live;
    logic [RAM_AW-1:0] r_held_addr;
    dphase_t           r_dp;

    gigatron_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_a_req      (i_a_req),
        .i_b_req      (i_b_req),
        .o_grant_a    (w_grant_a),
        .o_grant_b    (w_grant_b),
        .o_starve_cnt (o_dbg_starve_cnt)
    );

    assign w_any_grant = w_grant_a || w_grant_b;
    assign w_sel_we    = w_grant_b ? i_b_we    : i_a_we;
    assign w_sel_wdata = w_grant_b ? i_b_wdata : i_a_wdata;

    always_comb begin
        w_ram_addr = r_held_addr;
        if (i_reset) begin
            w_ram_addr = '0;
        end else if (w_grant_a) begin
            w_ram_addr = i_a_addr;
        end else if (w_grant_b) begin
            w_ram_addr = i_b_addr;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_dp        <= '0;
            r_held_addr <= '0;
        end else begin
            r_dp.valid <= w_any_grant;
            r_dp.owner <= w_grant_b ? PORT_B : PORT_A;
            r_dp.we    <= w_sel_we;
            r_dp.wdata <= w_sel_wdata;
            if (w_any_grant) begin
                r_held_addr <= w_ram_addr;
            end
        end
    end

    // A data phase still registered while reset is high is dropped here.
    assign w_dp_live   = r_dp.valid && !i_reset;

    assign o_a_ack     = w_grant_a;
    assign o_b_ack     = w_grant_b;
    assign o_ram_addr  = w_ram_addr;
    assign o_ram_we    = w_dp_live && r_dp.we;
    assign o_ram_wdata = o_ram_we ? r_dp.wdata : '0;

    assign o_a_rvalid  = w_dp_live && !r_dp.we && (r_dp.owner == PORT_A);
    assign o_b_rvalid  = w_dp_live && !r_dp.we && (r_dp.owner == PORT_B);
    assign o_a_rdata   = o_a_rvalid ? i_ram_rdata : '0;
    assign o_b_rdata   = o_b_rvalid ? i_ram_rdata : '0;

endmodule

// File: tb/tb_gigatron_ram_arbiter.sv
// Directed bench for gigatron_ram_arbiter: RAM model, transaction-level
// reference model checked every cycle, and hand-computed literal checks.
module tb_gigatron_ram_arbiter;
    import gigatron_ram_arbiter_pkg::*;

    localparam int LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [15:0] a_addr = 0, b_addr = 0;
    logic [7:0]  a_wdata = 0, b_wdata = 0;
    logic        a_ack, a_rvalid, b_ack, b_rvalid, ram_we;
    logic [7:0]  a_rdata, b_rdata, ram_wdata;
    logic [15:0] ram_addr;
    logic [7:0]  ram_rdata = 8'h00;
    logic [cnt_width(LIMIT)-1:0] dbg_cnt;

    gigatron_ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_a_req          (a_req),
        .i_a_we           (a_we),
        .i_a_addr         (a_addr),
        .i_a_wdata        (a_wdata),
        .o_a_ack          (a_ack),
        .o_a_rvalid       (a_rvalid),
        .o_a_rdata        (a_rdata),
        .i_b_req          (b_req),
        .i_b_we           (b_we),
        .i_b_addr         (b_addr),
        .i_b_wdata        (b_wdata),
        .o_b_ack          (b_ack),
        .o_b_rvalid       (b_rvalid),
        .o_b_rdata        (b_rdata),
        .o_ram_addr       (ram_addr),
        .o_ram_we         (ram_we),
        .o_ram_wdata      (ram_wdata),
        .i_ram_rdata      (ram_rdata),
        .o_dbg_starve_cnt (dbg_cnt)
    );

    // ---------------- RAM model ----------------
    function automatic logic [7:0] init_val(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h10;
            16'h0001: return 8'h21;
            16'h0002: return 8'h32;
            16'h0003: return 8'h43;
            16'h0042: return 8'h11;
            16'h0100: return 8'h3C;
            16'hBEEF: return 8'h77;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    logic [7:0]  ram_mem   [65536];
    bit          ram_dirty [65536];
    logic [15:0] ram_lat = 16'h0000;

    function automatic logic [7:0] ram_next(input logic [15:0] a);
        if (ram_we && ram_lat == a) return ram_wdata;
        return ram_dirty[a] ? ram_mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        ram_rdata <= ram_next(ram_addr);
        if (ram_we) begin
            ram_mem[ram_lat]   <= ram_wdata;
            ram_dirty[ram_lat] <= 1'b1;
        end
        ram_lat <= ram_addr;
    end

    // ---------------- scoreboard ----------------
    int n_compared   = 0;
    int n_mismatched = 0;
    bit done         = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transactions, a reference memory and a queue of
    // expected read returns {owner, data}.
    logic [7:0]  m_mem [logic [15:0]];
    logic [8:0]  exp_q [$];

    function automatic logic [7:0] m_read(input logic [15:0] a);
        return m_mem.exists(a) ? m_mem[a] : init_val(a);
    endfunction

    initial begin : compare
        int          m_starve;
        logic [15:0] m_held;
        bit          mp_valid, mp_we;
        logic [15:0] mp_addr;
        logic [7:0]  mp_wdata;
        bit          ga, gb, e_we, e_rva, e_rvb;
        logic [15:0] e_addr;
        logic [7:0]  e_wd, e_rd;
        logic [8:0]  ent;
        m_starve = 0; m_held = 0; mp_valid = 0; mp_we = 0; mp_addr = 0; mp_wdata = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            ga = 0; gb = 0; e_addr = 0; e_we = 0; e_wd = 0; e_rva = 0; e_rvb = 0; e_rd = 0;
            if (!rst) begin
                gb     = b_req && (!a_req || m_starve == LIMIT);
                ga     = a_req && !gb;
                e_addr = ga ? a_addr : (gb ? b_addr : m_held);
                e_we   = mp_valid && mp_we;
                e_wd   = e_we ? mp_wdata : 8'h00;
                if (mp_valid && !mp_we && exp_q.size() > 0) begin
                    ent   = exp_q.pop_front();
                    e_rvb = ent[8];
                    e_rva = !ent[8];
                    e_rd  = ent[7:0];
                end
            end
            check("a_ack", a_ack, ga);
            check("b_ack", b_ack, gb);
            check("ram_addr", ram_addr, e_addr);
            check("ram_we", ram_we, e_we);
            check("ram_wdata", ram_wdata, e_wd);
            check("a_rvalid", a_rvalid, e_rva);
            check("b_rvalid", b_rvalid, e_rvb);
            if (e_rva || rst) check("a_rdata", a_rdata, e_rd);
            if (e_rvb || rst) check("b_rdata", b_rdata, e_rd);
            if (!rst) check("starve_cnt", dbg_cnt, m_starve);
            // advance the model across the coming rising edge
            if (rst) begin
                mp_valid = 0; m_starve = 0; m_held = 0;
                exp_q.delete();
            end else begin
                if (e_we) m_mem[mp_addr] = mp_wdata;
                mp_valid = ga || gb;
                mp_we    = ga ? a_we : b_we;
                mp_wdata = ga ? a_wdata : b_wdata;
                mp_addr  = e_addr;
                if (mp_valid) begin
                    m_held = e_addr;
                    if (!mp_we) exp_q.push_back({gb, m_read(e_addr)});
                end
                if (!b_req || gb)                m_starve = 0;
                else if (ga && m_starve < LIMIT) m_starve = m_starve + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input bit req, input bit we, input logic [15:0] addr, input logic [7:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic drv_b(input bit req, input bit we, input logic [15:0] addr, input logic [7:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic idle_cycle();
        drv_a(0, 0, 16'h0, 8'h0);
        drv_b(0, 0, 16'h0, 8'h0);
        tick();
    endtask

    // ---------------- directed vectors ----------------
    initial begin : stim
        string      seq;
        logic [7:0] burst_exp [4];
        burst_exp[0] = 8'h10; burst_exp[1] = 8'h21; burst_exp[2] = 8'h32; burst_exp[3] = 8'h43;
        seq = "AAAABAAAAB";

        // A write held through reset, then A-only write/read of 0x1234
        rst = 1;
        drv_a(1, 1, 16'h1234, 8'h5A);
        @(negedge clk);
        check("lit_rst_a_ack", a_ack, 0);
        check("lit_rst_ram_addr", ram_addr, 16'h0000);
        check("lit_rst_ram_we", ram_we, 0);
        tick(); tick();
        rst = 0;
        @(negedge clk);
        check("lit_w_ack0", a_ack, 1);
        check("lit_w_addr0", ram_addr, 16'h1234);
        tick();
        drv_a(1, 0, 16'h1234, 8'h00);
        @(negedge clk);
        check("lit_r_ack1", a_ack, 1);
        check("lit_w_we1", ram_we, 1);
        check("lit_w_wdata1", ram_wdata, 8'h5A);
        tick();
        drv_a(0, 0, 16'h0, 8'h0);
        @(negedge clk);
        check("lit_r_rvalid2", a_rvalid, 1);
        check("lit_r_rdata2", a_rdata, 8'h5A);
        tick();

        // starvation with both ports requesting continuously
        drv_a(1, 0, 16'h2000, 8'h00);
        drv_b(1, 0, 16'h3000, 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("lit_starve_grant%0d", i), {a_ack, b_ack},
                  (seq[i] == "B") ? 2'b01 : 2'b10);
            tick();
        end
        idle_cycle();

        // A write and B read of 0x0100 in the same cycle
        drv_a(1, 1, 16'h0100, 8'hC3);
        drv_b(1, 0, 16'h0100, 8'h00);
        @(negedge clk);
        check("lit_il_acks0", {a_ack, b_ack}, 2'b10);
        tick();
        drv_a(0, 0, 16'h0, 8'h0);
        @(negedge clk);
        check("lit_il_acks1", {a_ack, b_ack}, 2'b01);
        check("lit_il_wdata1", ram_wdata, 8'hC3);
        tick();
        drv_b(0, 0, 16'h0, 8'h0);
        @(negedge clk);
        check("lit_il_rvalid2", {a_rvalid, b_rvalid}, 2'b01);
        check("lit_il_rdata2", b_rdata, 8'hC3);
        tick();

        // reset during the data phase of a write to 0x0042
        drv_a(1, 1, 16'h0042, 8'hFF);
        @(negedge clk);
        check("lit_rw_ack", a_ack, 1);
        tick();
        drv_a(0, 0, 16'h0, 8'h0);
        rst = 1;
        @(negedge clk);
        check("lit_rw_we_in_rst", ram_we, 0);
        check("lit_rw_addr_in_rst", ram_addr, 16'h0000);
        tick();
        rst = 0;
        @(negedge clk);
        check("lit_rw_we_after", ram_we, 0);
        tick();
        drv_a(1, 0, 16'h0042, 8'h00);
        @(negedge clk);
        check("lit_rw_rd_ack", a_ack, 1);
        tick();
        drv_a(0, 0, 16'h0, 8'h0);
        @(negedge clk);
        check("lit_rw_rvalid", a_rvalid, 1);
        check("lit_rw_old_data", a_rdata, 8'h11);
        tick();

        // idle after a grant of 0xBEEF
        drv_a(1, 0, 16'hBEEF, 8'h00);
        @(negedge clk);
        check("lit_idle_grant_addr", ram_addr, 16'hBEEF);
        tick();
        drv_a(0, 0, 16'h0, 8'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("lit_idle_addr%0d", i), ram_addr, 16'hBEEF);
            check($sformatf("lit_idle_ack%0d", i), {a_ack, b_ack, ram_we}, 3'b000);
            check($sformatf("lit_idle_rvalid%0d", i), {a_rvalid, b_rvalid}, (i == 0) ? 2'b10 : 2'b00);
            tick();
        end

        // B burst reading 0x0000..0x0003
        drv_b(1, 0, 16'h0000, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("lit_burst_ack%0d", i), b_ack, (i < 4) ? 1 : 0);
            check($sformatf("lit_burst_rvalid%0d", i), b_rvalid, (i > 0) ? 1 : 0);
            if (i > 0) check($sformatf("lit_burst_rdata%0d", i), b_rdata, burst_exp[i-1]);
            tick();
            if (i < 3) drv_b(1, 0, 16'(i + 1), 8'h00);
            else       drv_b(0, 0, 16'h0, 8'h00);
        end
        @(negedge clk);
        check("lit_burst_quiet", {b_ack, b_rvalid}, 2'b00);

        tick();
        done = 1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_mismatched++;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gigatron_ram_arbiter.md
GIGATRON_RAM_ARBITER -- requirements
Module: gigatron_ram_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive A grants while B is waiting.
REQ-002 The block SHALL have port i_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port i_a_req, input, 1, the port A (CPU side, preferred) request.
REQ-005 The block SHALL have port i_a_we, input, 1, the port A write flag (1 = write, 0 = read).
REQ-006 The block SHALL have port i_a_addr, input, 16, the port A address.
REQ-007 The block SHALL have port i_a_wdata, input, 8, the port A write data.
REQ-008 The block SHALL have port o_a_ack, output, 1, meaning the port A request is accepted at this clock edge.
REQ-009 The block SHALL have port o_a_rvalid, output, 1, meaning o_a_rdata is valid this cycle.
REQ-010 The block SHALL have port o_a_rdata, output, 8, the port A read data.
REQ-011 Port B SHALL have i_b_req, i_b_we, i_b_addr[15:0], i_b_wdata[7:0], o_b_ack, o_b_rvalid and o_b_rdata[7:0], each identical in meaning to its port A counterpart.
REQ-012 The block SHALL have port o_ram_addr, output, 16, driving the RAM address, which the RAM registers on each edge.
REQ-013 The block SHALL have port o_ram_we, output, 1, the RAM write enable; the RAM writes at its previously latched address.
REQ-014 The block SHALL have port o_ram_wdata, output, 8, the RAM write data.
REQ-015 The block SHALL have port i_ram_rdata, input, 8, the RAM read data for the latched address.

Function
REQ-016 Every transaction SHALL take two cycles: an address phase in cycle N and a data phase in cycle N+1.
REQ-017 Address phases SHALL overlap the previous data phase, giving a throughput of one transaction per cycle.
REQ-018 A requester SHALL hold req, we, addr and wdata stable until it sees ack high at a rising edge.
REQ-019 ack SHALL be combinational and SHALL be high in the address-phase cycle.
REQ-020 At most one of o_a_ack and o_b_ack SHALL be high in any cycle.
REQ-021 When only one port requests, that port SHALL be granted.
REQ-022 When both ports request, A SHALL be granted unless the starvation counter equals STARVE_LIMIT, in which case B SHALL be granted.
REQ-023 The starvation counter SHALL increment on each cycle in which A is granted while i_b_req is high, saturating at STARVE_LIMIT.
REQ-024 The starvation counter SHALL clear on a B grant or on any cycle in which i_b_req is low.
REQ-025 In an address phase, o_ram_addr SHALL equal the granted port's address.
REQ-026 With no grant, o_ram_addr SHALL hold the last granted address, or 0 after reset.
REQ-027 The block SHALL register the owner, we, wdata and a valid bit into a data-phase stage at each grant edge.
REQ-028 In a write data phase, o_ram_we SHALL be 1 and o_ram_wdata SHALL equal the captured wdata.
REQ-029 In a read data phase, o_x_rvalid SHALL be 1 for the owner only, and o_x_rdata SHALL pass i_ram_rdata combinationally.
REQ-030 A write data phase SHALL NOT assert rvalid.
REQ-031 o_ram_we SHALL be 0 whenever the data-phase stage is invalid.
REQ-032 o_ram_wdata SHALL be 0 when o_ram_we is 0.
REQ-033 A read issued in the cycle after a write to the same address SHALL return the new data, with no stall.
REQ-034 Back-to-back requests from the same port SHALL be acked on consecutive cycles.
REQ-035 Requests arriving while a data phase is in progress SHALL NOT be delayed.

Reset
REQ-036 While i_reset is high, o_a_ack, o_b_ack, o_ram_we, o_a_rvalid and o_b_rvalid SHALL all be 0.
REQ-037 While i_reset is high, o_ram_addr SHALL be 0 and o_*_rdata SHALL be 0.
REQ-038 At the edge where i_reset is high, the data-phase valid bit SHALL clear, the starvation counter SHALL clear, and the held address SHALL become 0.
REQ-039 A data phase in flight when reset asserts SHALL be dropped: no write occurs and no rvalid is issued.
REQ-040 Requests held through reset SHALL be acked on the first cycle after i_reset falls.

Structure
REQ-041 Port indices (PORT_A = 0, PORT_B = 1) and the RAM address and data widths SHALL live in the shared gigatron definitions include file.
REQ-042 The grant and starvation logic SHALL be the single sub-module gigatron_arb_pick, taking both req bits as inputs and producing grant_a, grant_b and the counter.
REQ-043 The two-stage pipeline registers SHALL remain in gigatron_ram_arbiter.
REQ-044 The design SHALL be synthesizable and SHALL use no latches.

Verification
REQ-045 The bench SHALL cover an A-only write: A writes 0x5A to 0x1234 and then reads 0x1234, which SHALL give ack on cycles 0 and 1, o_ram_we=1 in cycle 1, and o_a_rvalid=1 with o_a_rdata=0x5A in cycle 2.
REQ-046 The bench SHALL cover starvation: with A and B requesting continuously and STARVE_LIMIT=4, the grant sequence SHALL be A,A,A,A,B,A,A,A,A,B.
REQ-047 The bench SHALL cover an A/B interleave: B reads 0x0100 (preloaded 0x3C) while A writes 0x0100=0xC3 in the same cycle; A SHALL win first, and B SHALL read 0xC3 one cycle later.
REQ-048 The bench SHALL cover reset mid-write: A issues a write of 0xFF to 0x0042, and i_reset is high during its data phase; o_ram_we SHALL stay 0 and 0x0042 SHALL keep its old value.
REQ-049 The bench SHALL cover idle: with no requests for 5 cycles after a grant of 0xBEEF, o_ram_addr SHALL stay 0xBEEF, and no ack, rvalid or we SHALL appear.
REQ-050 The bench SHALL cover a B-only burst: B reads 0x0000 through 0x0003 on consecutive cycles, giving four acks and then four rvalids, each one cycle late and in order.
